// File: rtl/adder_result_collector.sv
// adder_result_collector
//   Downstream stage of the pipelined 16-bit adder. Tracks which adder cycles
//   carry a valid operand pair, captures {cout,sum} LATENCY cycles after issue
//   and buffers the results in a DEPTH-entry show-ahead FIFO with a valid/ready
//   output. issue_ready is a credit signal: outstanding results (FIFO occupancy
//   plus operands still inside the adder) never exceed DEPTH, so a capture can
//   never meet a full FIFO.
//   Optional feature macro: SUM_ACCUM_EN -- push a running ACC_W-bit sum of
//   the captured values instead of the raw values, with a sticky wrap flag.
module adder_result_collector #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int ACC_W   = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [15:0]              sum_in,
    input  logic                     cout_in,
    input  logic                     acc_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     acc_wrap
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LATENCY-1:0] r_vld;
    logic [ACC_W-1:0]   r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_issue_acc;
    logic               w_capture;
    logic               w_pop;
    logic [31:0]        w_inflight;
    logic [ACC_W-1:0]   w_v;
    logic [ACC_W-1:0]   w_push_data;

    assign w_issue_acc = issue_valid & issue_ready;
    assign w_capture   = r_vld[LATENCY-1];
    assign w_pop       = out_valid & out_ready;
    assign w_v         = ACC_W'({cout_in, sum_in});

    // Count operands currently travelling through the adder
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + 32'(r_vld[i]);
        end
    end

    // Credit check uses registered occupancy only, so a pop frees credit next cycle
    assign issue_ready = ((32'(r_count) + w_inflight) < 32'(DEPTH));

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_count = r_count;

    // Valid delay line mirroring the adder pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_issue_acc;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // FIFO storage; contents need no reset because out_data is gated by occupancy
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SUM_ACCUM_EN
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_wrap;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W:0]   w_acc_next;

    // Running sum; acc_clr restarts it from the value captured in the same cycle
    always_comb begin
        w_acc_base = acc_clr ? {ACC_W{1'b0}} : r_acc;
        w_acc_next = {1'b0, w_acc_base} + {1'b0, w_v};
    end

    assign w_push_data = w_acc_next[ACC_W-1:0];
    assign acc_wrap    = r_acc_wrap;

    // Accumulator and sticky wrap flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_acc_wrap <= 1'b0;
        end else if (w_capture) begin
            r_acc      <= w_acc_next[ACC_W-1:0];
            r_acc_wrap <= (acc_clr ? 1'b0 : r_acc_wrap) | w_acc_next[ACC_W];
        end else if (acc_clr) begin
            r_acc      <= '0;
            r_acc_wrap <= 1'b0;
        end
    end
`else
    logic w_unused_acc_clr;

    assign w_push_data      = w_v;
    assign acc_wrap         = 1'b0;
    assign w_unused_acc_clr = acc_clr;
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// tb_adder_result_collector
//   Directed bench for adder_result_collector. A small behavioural model of the
//   upstream adder produces sum_in/cout_in LATENCY cycles after issue; a queue
//   of expected results is filled on every accepted issue and compared against
//   every popped FIFO head. Build with +define+SUM_ACCUM_EN to cover the
//   accumulator variant.
module tb_adder_result_collector;
    localparam int LATENCY = 1;
    localparam int DEPTH   = 4;
    localparam int ACC_W   = 24;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic [15:0]      sum_in;
    logic             cout_in;
    logic             acc_clr = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             acc_wrap;

    logic [15:0]      a = '0;
    logic [15:0]      b = '0;
    logic [16:0]      pipe [LATENCY];

    int               n_checks = 0;
    int               n_errors = 0;
    int               n_acc;
    logic             took;
    logic [ACC_W-1:0] q [$];
    logic [ACC_W-1:0] last_pop = '0;
    logic [ACC_W-1:0] m_acc = '0;
    logic             m_wrap = 1'b0;

    always #5 clk = ~clk;

    // Upstream adder model
    always @(posedge clk) begin
        pipe[0] <= {1'b0, a} + {1'b0, b};
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign {cout_in, sum_in} = pipe[LATENCY-1];

    adder_result_collector #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .ACC_W   (ACC_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .sum_in      (sum_in),
        .cout_in     (cout_in),
        .acc_clr     (acc_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .acc_wrap    (acc_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard the coming clock edge, then advance to the next falling edge
    task automatic step();
        logic [16:0] v;
`ifdef SUM_ACCUM_EN
        logic [ACC_W:0] nxt;
`endif
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("pop_unexpected", 32'(out_valid), 32'd0);
            end else begin
                last_pop = out_data;
                check("order", 32'(out_data), 32'(q.pop_front()));
            end
        end
        if (issue_valid && issue_ready) begin
            v = {1'b0, a} + {1'b0, b};
`ifdef SUM_ACCUM_EN
            nxt    = (acc_clr ? {(ACC_W+1){1'b0}} : {1'b0, m_acc}) + (ACC_W+1)'(v);
            m_wrap = (acc_clr ? 1'b0 : m_wrap) | nxt[ACC_W];
            m_acc  = nxt[ACC_W-1:0];
            q.push_back(m_acc);
`else
            q.push_back(ACC_W'(v));
`endif
        end
        @(negedge clk);
    endtask

    task automatic enter_reset();
        reset_n = 1'b0;
        q.delete();
        m_acc  = '0;
        m_wrap = 1'b0;
    endtask

    initial begin
        // 1: reset, then reset again mid-stream with results in flight
        enter_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ready", 32'(issue_ready), 32'd1);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_wrap", 32'(acc_wrap), 32'd0);
        reset_n = 1'b1;
        step();
        a = 16'h0101; b = 16'h0202; issue_valid = 1'b1;
        step();
        step();
        issue_valid = 1'b0;
        check("pre_rst_count", 32'(out_count), 32'd1);
        enter_reset();
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        step();
        reset_n = 1'b1;
        repeat (4) step();
        check("no_stale_valid", 32'(out_valid), 32'd0);
        check("no_stale_count", 32'(out_count), 32'd0);

        // 2: single issue, latency and pop
        a = 16'h1234; b = 16'h0FFF; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        check("t2_early_valid", 32'(out_valid), 32'd0);
        repeat (LATENCY) step();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(out_data), 32'h002233);
        check("t2_count", 32'(out_count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_pop_count", 32'(out_count), 32'd0);
        check("t2_pop_valid", 32'(out_valid), 32'd0);
        check("t2_empty_data", 32'(out_data), 32'd0);

        // 3: carry out lands in bit 16 (acc_clr keeps the accumulator variant comparable)
        acc_clr = 1'b1;
        a = 16'hFFFF; b = 16'h0001; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        repeat (LATENCY) step();
        acc_clr = 1'b0;
        check("t3_data", 32'(out_data), 32'h010000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 4: backpressure limits issues to DEPTH credits
        a = 16'h0010; b = 16'h0000; issue_valid = 1'b1; n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            took = issue_ready;
            step();
            if (took) begin n_acc++; a = a + 16'd1; end
        end
        issue_valid = 1'b0;
        check("bp_accepted", 32'(n_acc), 32'(DEPTH));
        check("bp_ready", 32'(issue_ready), 32'd0);
        check("bp_count", 32'(out_count), 32'(DEPTH));
        check("bp_head", 32'(out_data), 32'(q[0]));
        out_ready = 1'b1;
        check("bp_ready_at_pop", 32'(issue_ready), 32'd0);
        step();
        check("bp_credit_next", 32'(issue_ready), 32'd1);
        check("bp_count_after_pop", 32'(out_count), 32'(DEPTH - 1));
        repeat (3) step();
        check("bp_drained", 32'(out_count), 32'd0);
        out_ready = 1'b0;

        // 5: push and pop in the same cycle at count 3, then stream across wraps
        a = 16'h0040; b = 16'h0003; issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            took = issue_ready;
            step();
            if (took) a = a + 16'd1;
        end
        issue_valid = 1'b0;
        check("pp_pre_count", 32'(out_count), 32'd3);
        check("pp_pre_ready", 32'(issue_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("pp_count_hold", 32'(out_count), 32'd3);
        issue_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            took = issue_ready;
            step();
            if (took) a = a + 16'd5;
        end
        issue_valid = 1'b0;
        repeat (LATENCY + 5) step();
        check("pp_drained", 32'(out_count), 32'd0);
        check("pp_queue_empty", 32'(q.size()), 32'd0);
        out_ready = 1'b0;

`ifdef SUM_ACCUM_EN
        // 6: accumulator wrap at 257 x FFFF, then clear with capture
        enter_reset();
        @(negedge clk);
        reset_n = 1'b1;
        a = 16'hFFFF; b = 16'h0000; out_ready = 1'b1; issue_valid = 1'b1; n_acc = 0;
        for (int i = 0; i < 1000 && n_acc < 256; i++) begin
            took = issue_ready;
            step();
            if (took) n_acc++;
        end
        issue_valid = 1'b0;
        repeat (LATENCY + 3) step();
        check("acc_256_issued", 32'(n_acc), 32'd256);
        check("acc_256_data", 32'(last_pop), 32'hFFFF00);
        check("acc_256_wrap", 32'(acc_wrap), 32'd0);
        issue_valid = 1'b1;
        for (int i = 0; i < 1000 && n_acc < 300; i++) begin
            took = issue_ready;
            step();
            if (took) n_acc++;
        end
        issue_valid = 1'b0;
        repeat (LATENCY + 3) step();
        check("acc_300_data", 32'(last_pop), 32'h2BFED4);
        check("acc_300_wrap", 32'(acc_wrap), 32'd1);
        check("acc_model_wrap", 32'(acc_wrap), 32'(m_wrap));
        out_ready = 1'b0;
        acc_clr = 1'b1; a = 16'h0005; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        repeat (LATENCY) step();
        acc_clr = 1'b0;
        check("acc_clr_data", 32'(out_data), 32'd5);
        check("acc_clr_wrap", 32'(acc_wrap), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`else
        check("wrap_tied", 32'(acc_wrap), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
